// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  localparam int          DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
endpackage

// File: rtl/adder.sv
// Combinational carry-lookahead adder: 4-bit groups with group generate/propagate.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g, p, c;
  logic [NG-1:0]    gg, pp;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign pp[k] = &p[4*k +: 4];
  end

  // Group carries come from gg/pp; bit carries are only resolved inside a group.
  always_comb begin
    logic cg, cb;
    cg = cin;
    c  = '0;
    for (int k = 0; k < NG; k++) begin
      cb = cg;
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = cb;
        cb = g[4*k+j] | (p[4*k+j] & cb);
      end
      cg = gg[k] | (pp[k] & cg);
    end
    cout = cg;
  end

  assign sum = p ^ c;
endmodule

// File: rtl/subtractor_33.sv
// 33-bit a - b as a + ~b + 1: the 32-bit CLA adder plus a 1-bit top stage.
module subtractor_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic        neg
);
  logic c31;

  adder #(.WIDTH(32)) u_lo (
    .a    (a[31:0]),
    .b    (~b[31:0]),
    .cin  (1'b1),
    .sum  (diff[31:0]),
    .cout (c31)
  );

  assign diff[32] = a[32] ^ ~b[32] ^ c31;
  assign neg      = diff[32];
endmodule

// File: rtl/divider.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Signed division is built only when DIVIDER_SIGNED_EN is defined.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dzf_q, dzf_d;

  // Iteration datapath: shifted partial remainder minus divisor.
  logic [WIDTH:0]   p_sh, diff;
  logic             diff_neg;

  assign p_sh = {p_q[WIDTH-1:0], a_q[WIDTH-1]};

  subtractor_33 u_sub (
    .a    (p_sh),
    .b    ({1'b0, b_q}),
    .diff (diff),
    .neg  (diff_neg)
  );

  logic [WIDTH-1:0] a_load, b_load, q_fix, r_fix;
  logic             q_neg_load, r_neg_load;

`ifdef DIVIDER_SIGNED_EN
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [WIDTH-1:0] neg_x_in, neg_y_in;
  logic [WIDTH:0]   neg_x, neg_y;
  logic             neg_x_s, neg_y_s;
  logic             unused_neg;

  // Two negators shared: operand abs() at load, result fix-up in FIX.
  assign neg_x_in = (state_q == FIX) ? a_q          : dividend;
  assign neg_y_in = (state_q == FIX) ? p_q[WIDTH-1:0] : divisor;

  subtractor_33 u_neg_x (.a(33'd0), .b({1'b0, neg_x_in}), .diff(neg_x), .neg(neg_x_s));
  subtractor_33 u_neg_y (.a(33'd0), .b({1'b0, neg_y_in}), .diff(neg_y), .neg(neg_y_s));

  assign unused_neg = ^{neg_x[WIDTH], neg_y[WIDTH], neg_x_s, neg_y_s};
  assign a_load     = (sign & dividend[WIDTH-1]) ? neg_x[WIDTH-1:0] : dividend;
  assign b_load     = (sign & divisor[WIDTH-1])  ? neg_y[WIDTH-1:0] : divisor;
  assign q_neg_load = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign r_neg_load = sign & dividend[WIDTH-1];
  assign q_fix      = q_neg_q ? neg_x[WIDTH-1:0] : a_q;
  assign r_fix      = r_neg_q ? neg_y[WIDTH-1:0] : p_q[WIDTH-1:0];
`else
  logic unused_sign;

  assign unused_sign = ^{sign, p_q[WIDTH]};
  assign a_load      = dividend;
  assign b_load      = divisor;
  assign q_neg_load  = 1'b0;
  assign r_neg_load  = 1'b0;
  assign q_fix       = a_q;
  assign r_fix       = p_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzf_d   = dzf_q;
`ifdef DIVIDER_SIGNED_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = b_load;
          p_d   = '0;
          cnt_d = '0;
`ifdef DIVIDER_SIGNED_EN
          q_neg_d = q_neg_load;
          r_neg_d = r_neg_load;
`endif
          if (divisor == '0) begin
            // Raw dividend is kept in A so FIX can return it as the remainder.
            a_d     = dividend;
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            a_d     = a_load;
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = diff_neg ? p_sh : diff;
        a_d   = {a_q[WIDTH-2:0], ~diff_neg};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        dzf_d   = dz_q;
        quot_d  = dz_q ? DIV_ZERO_Q : q_fix;
        rem_d   = dz_q ? a_q        : r_fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzf_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzf_q   <= dzf_d;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzf_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, start-while-busy, mid-op reset, random back-to-back ops.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst_n, start, sign;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] n, input logic [31:0] d, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint ln, ld, lq, lr;
    logic   use_signed;
`ifdef DIVIDER_SIGNED_EN
    use_signed = s;
`else
    use_signed = 1'b0;
`endif
    if (d == 32'd0) begin
      q = 32'hFFFFFFFF; r = n; dz = 1'b1;
    end else begin
      if (use_signed) begin
        ln = longint'($signed(n));
        ld = longint'($signed(d));
      end else begin
        ln = longint'({32'd0, n});
        ld = longint'({32'd0, d});
      end
      lq = ln / ld;
      lr = ln % ld;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  // inject > 0 pulses start with other operands after that many busy cycles.
  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        input logic s, input int inject);
    logic [31:0] eq, er;
    logic        edz;
    int          cycles, busy_cnt;
    logic        overlap, seen;
    model(n, d, s, eq, er, edz);
    dividend = n; divisor = d; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; busy_cnt = 0; overlap = 1'b0; seen = 1'b0;
    while (cycles < 60 && !seen) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) seen = 1'b1;
      else if (inject > 0 && cycles == inject) begin
        dividend = 32'h0000_0FFF; divisor = 32'd5; sign = ~s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"},   cycles,   (d == 0) ? 32'd2 : 32'd34);
    check({tag, " busy_cycles"}, busy_cnt, (d == 0) ? 32'd1 : 32'd33);
    check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, " quotient"},  quotient,  eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset busy",  32'(busy), 32'd0);
    check("reset done",  32'(done), 32'd0);
    check("reset quotient",  quotient,  32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u100/7",        32'd100,        32'd7,          1'b0, 0);
    run_op("s-7/2",         32'hFFFFFFF9,   32'd2,          1'b1, 0);
    run_op("div0",          32'h1234,       32'd0,          1'b0, 0);
    run_op("s_ovf",         32'h80000000,   32'hFFFFFFFF,   1'b1, 0);
    run_op("uFFFFFFFF/1",   32'hFFFFFFFF,   32'd1,          1'b0, 0);
    run_op("s7/-2",         32'd7,          32'hFFFFFFFE,   1'b1, 0);
    run_op("s_div0",        32'h80000001,   32'd0,          1'b1, 0);
    run_op("start_busy",    32'd1000,       32'd33,         1'b0, 5);

    // Reset in the middle of an operation: discard it, outputs clear.
    dividend = 32'd12345; divisor = 32'd17; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy",  32'(busy), 32'd0);
    check("midreset done",  32'(done), 32'd0);
    check("midreset quotient",  quotient,  32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset div_by_zero", 32'(div_by_zero), 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("midreset no_done", 32'(seen_done), 32'd0);
    run_op("u9/3", 32'd9, 32'd3, 1'b0, 0);

    // Random operations, each started in the previous done cycle.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] rn, rd;
      rn = $urandom;
      case ($urandom_range(0, 3))
        0:       rd = 32'(($urandom_range(1, 15)));
        1:       rd = (i % 6 == 0) ? 32'd0 : $urandom;
        2:       rd = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rd = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("rand", rn, rd, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
